comparador_serial_ctrl: RTL and testbench
=========================================

# comparador_serial_ctrl

Bit-serial sequencer for the A/B comparison datapath. It latches two WIDTH-bit operands and a two-bit mode (z, y) on a start request. It then walks the operands from MSB to LSB (left to right), one bit position per clock, carrying the equal/greater state between positions, and asserts a one-cycle done with the registered result f. It sits in front of the cell chain as its controller, so a single reusable cell evaluates arbitrarily wide operands under handshake control.

## Interface
- WIDTH, 3, operand width in bits (≥1); also the number of scan cycles.
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; captured when start is accepted.
- B  input  WIDTH  operand B; captured when start is accepted.
- z  input  1  mode bit 1; captured with A/B.
- y  input  1  mode bit 0; captured with A/B.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse: f holds a new result.
- f  output  1  registered comparison result.
- idx  output  $clog2(WIDTH) (min 1)  bit position being processed; debug/observation.

## Operation
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, f=0, idx=0, internal eq=1, gt=0.
- Mode {z,y}:
  - 00: f = (A==B)
  - 01: f = (A>B)
  - 10: f = (A<B)
  - 11: f = (A!=B)
- Comparison is unsigned.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1: capture A, B, z, y into a_r, b_r, m_r; set idx=WIDTH-1, eq=1, gt=0; go to SCAN.
  - start=0: stay in IDLE.
- SCAN, per cycle, on bit i=idx:
  - eq=1 and a_r[i]=1, b_r[i]=0: eq←0, gt←1.
  - eq=1 and a_r[i]=0, b_r[i]=1: eq←0, gt←0.
  - Otherwise eq and gt hold. Once eq=0 the state is frozen for the remaining bits.
  - idx decrements each cycle. After bit 0 is processed, go to DONE.
  - No early exit: SCAN always takes exactly WIDTH cycles.
- Result: lt = ~eq & ~gt. f is registered on the SCAN→DONE transition, using the next-state eq/gt that include bit 0.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- f holds its value until the next DONE entry or reset.
- start outside IDLE (SCAN, DONE) is ignored. It is neither queued nor does it restart the scan.
- Changes on A/B/z/y after capture have no effect on the operation in progress.
- rst during SCAN or DONE aborts: outputs return to reset values on the next edge, and no done is issued.
- rst and start high together: rst wins.

## Timing
- start sampled high at edge n, in IDLE: busy=1 from edge n.
- SCAN covers edges n+1 … n+WIDTH. Bit WIDTH-1 is processed at edge n+1, bit 0 at edge n+WIDTH.
- State is DONE after edge n+WIDTH. done=1 and the new f are valid in the cycle between edges n+WIDTH and n+WIDTH+1.
- At edge n+WIDTH+1: IDLE, busy=0, done=0.
- Earliest next accepted start is at edge n+WIDTH+2. Throughput is one comparison per WIDTH+2 cycles.
- For WIDTH=3: done is high 3 edges after start is sampled; busy is high for 4 cycles.

## Test plan
- Reset: assert rst for 2 cycles with start=1 → busy=0, done=0, f=0, idx=0; no operation starts.
- Greater-than, WIDTH=3: A=5, B=3, {z,y}=01, start one cycle → idx sequence 2,1,0; done pulses once, 3 edges after start; f=1, busy low on the following cycle.
- Less-than and frozen state: A=3, B=4, {z,y}=10 → f=1. Then A=4, B=3, {z,y}=10 → f=0. The MSB decides the result; later bits do not change it.
- Equality and inequality: A=B=6 with {z,y}=00 → f=1. A=B=6 with {z,y}=11 → f=0. A=6, B=7 with {z,y}=11 → f=1.
- Start while busy and operand change: start A=1, B=2, mode 01. Pulse start again and change A to 7 during SCAN. → single done at the original time, f=0, no second operation. f holds 0 across the following idle cycles.
- Reset mid-scan: start A=7, B=0, mode 01; assert rst at the second SCAN edge → no done pulse, f=0, state IDLE. A new start then completes normally with f=1.

Source files
------------

// File: rtl/comparador_serial_ctrl_if.sv
// Handshake/operand bundle between a requester and the bit-serial comparator.
// master drives the request side; slave is the comparator.
interface comparador_serial_ctrl_if #(
    parameter int WIDTH = 3,
    parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             z;
    logic             y;
    logic             busy;
    logic             done;
    logic             f;
    logic [IW-1:0]    idx;

    modport master (
        output start, A, B, z, y,
        input  busy, done, f, idx
    );

    modport slave (
        input  start, A, B, z, y,
        output busy, done, f, idx
    );
endinterface

// File: rtl/comparador_serial_ctrl.sv
// Bit-serial MSB-first unsigned comparator controller: captures A/B/mode on start,
// scans one bit per clock, then pulses done with the registered result f.
module comparador_serial_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    comparador_serial_ctrl_if.slave  bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       m_q, m_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             f_q, f_d;

    // One-bit compare cell, with eq/gt frozen once a difference has been seen.
    logic a_bit, b_bit;
    logic eq_nxt, gt_nxt, lt_nxt;
    logic f_nxt;

    always_comb begin
        a_bit  = a_q[idx_q];
        b_bit  = b_q[idx_q];
        eq_nxt = eq_q;
        gt_nxt = gt_q;
        if (eq_q && a_bit && !b_bit) begin
            eq_nxt = 1'b0;
            gt_nxt = 1'b1;
        end else if (eq_q && !a_bit && b_bit) begin
            eq_nxt = 1'b0;
            gt_nxt = 1'b0;
        end
        lt_nxt = ~eq_nxt & ~gt_nxt;
        case (m_q)
            2'b00:   f_nxt = eq_nxt;
            2'b01:   f_nxt = gt_nxt;
            2'b10:   f_nxt = lt_nxt;
            default: f_nxt = ~eq_nxt;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        f_d     = f_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    m_d     = {bus.z, bus.y};
                    idx_d   = IW'(WIDTH - 1);
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                eq_d = eq_nxt;
                gt_d = gt_nxt;
                // Always the full WIDTH cycles; f is taken from the state including bit 0.
                if (idx_q == '0) begin
                    f_d     = f_nxt;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b1;
            gt_q    <= 1'b0;
            f_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            f_q     <= f_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.f    = f_q;
    assign bus.idx  = idx_q;

    a_done_one_cycle: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_DONE) |=> (state_q == S_IDLE));
endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Directed-vector bench for comparador_serial_ctrl (WIDTH=3).
module tb_comparador_serial_ctrl;
    localparam int WIDTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    comparador_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    comparador_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; returns just after the accepting edge.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] zy);
        bus.A     = a;
        bus.B     = b;
        {bus.z, bus.y} = zy;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!bus.done && edges < 12) begin
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.A = 3'd5; bus.B = 3'd3; bus.z = 1'b0; bus.y = 1'b1;
        step();
        step();
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        vectors++; if (bus.f !== 1'b0) begin errors++; $display("FAIL reset_f got=%b exp=0", bus.f); end
        vectors++; if (bus.idx !== '0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", bus.idx); end
        bus.start = 1'b0;
        step();
        rst = 1'b0;
        step();
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_no_op got=%b exp=0", bus.busy); end
    endtask

    task automatic test_greater();
        launch(3'd5, 3'd3, 2'b01);
        vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL gt_busy_start got=%b exp=1", bus.busy); end
        vectors++; if (bus.idx !== 2'd2) begin errors++; $display("FAIL gt_idx0 got=%0d exp=2", bus.idx); end
        step();
        vectors++; if (bus.idx !== 2'd1 || bus.done !== 1'b0) begin errors++; $display("FAIL gt_idx1 got idx=%0d done=%b exp idx=1 done=0", bus.idx, bus.done); end
        step();
        vectors++; if (bus.idx !== 2'd0 || bus.done !== 1'b0) begin errors++; $display("FAIL gt_idx2 got idx=%0d done=%b exp idx=0 done=0", bus.idx, bus.done); end
        step();
        vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL gt_done got done=%b busy=%b exp 1 1", bus.done, bus.busy); end
        vectors++; if (bus.f !== 1'b1) begin errors++; $display("FAIL gt_f got=%b exp=1", bus.f); end
        step();
        vectors++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL gt_after got done=%b busy=%b exp 0 0", bus.done, bus.busy); end
        vectors++; if (bus.f !== 1'b1) begin errors++; $display("FAIL gt_f_hold got=%b exp=1", bus.f); end
    endtask

    // Table rows: {A, B, zy, expected f}, hand-computed.
    task automatic run_table(input string name, input logic [8:0] rows [], input int n);
        int edges;
        for (int i = 0; i < n; i++) begin
            launch(rows[i][8:6], rows[i][5:3], rows[i][2:1]);
            wait_done(edges);
            vectors++;
            if (edges !== WIDTH || bus.done !== 1'b1) begin
                errors++; $display("FAIL %s_lat[%0d] got edges=%0d done=%b exp edges=%0d done=1", name, i, edges, bus.done, WIDTH);
            end
            vectors++;
            if (bus.f !== rows[i][0]) begin
                errors++; $display("FAIL %s_f[%0d] got=%b exp=%b", name, i, bus.f, rows[i][0]);
            end
            step();
        end
    endtask

    task automatic test_less();
        logic [8:0] rows [] = '{ {3'd3, 3'd4, 2'b10, 1'b1},
                                 {3'd4, 3'd3, 2'b10, 1'b0},
                                 {3'd4, 3'd3, 2'b01, 1'b1} };
        run_table("lt", rows, 3);
    endtask

    task automatic test_equality();
        logic [8:0] rows [] = '{ {3'd6, 3'd6, 2'b00, 1'b1},
                                 {3'd6, 3'd6, 2'b11, 1'b0},
                                 {3'd6, 3'd6, 2'b01, 1'b0},
                                 {3'd6, 3'd7, 2'b11, 1'b1},
                                 {3'd0, 3'd0, 2'b10, 1'b0} };
        run_table("eq", rows, 5);
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        int first = -1;
        launch(3'd1, 3'd2, 2'b01);
        bus.start = 1'b1;
        bus.A = 3'd7;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 2) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (first < 0) first = k;
                vectors++; if (bus.f !== 1'b0) begin errors++; $display("FAIL busy_f got=%b exp=0", bus.f); end
            end
        end
        vectors++; if (dones !== 1) begin errors++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
        vectors++; if (first !== WIDTH) begin errors++; $display("FAIL busy_done_time got=%0d exp=%0d", first, WIDTH); end
        vectors++; if (bus.f !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL busy_idle_hold got f=%b busy=%b exp 0 0", bus.f, bus.busy); end
    endtask

    task automatic test_reset_mid_scan();
        int edges;
        int dones = 0;
        launch(3'd6, 3'd7, 2'b11);
        wait_done(edges);
        step();
        vectors++; if (bus.f !== 1'b1) begin errors++; $display("FAIL rmid_pre_f got=%b exp=1", bus.f); end
        launch(3'd7, 3'd0, 2'b01);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.f !== 1'b0 || bus.idx !== '0) begin
            errors++; $display("FAIL rmid_state got busy=%b done=%b f=%b idx=%0d exp 0 0 0 0", bus.busy, bus.done, bus.f, bus.idx);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.done) dones++;
        end
        vectors++; if (dones !== 0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=0", dones); end
        launch(3'd7, 3'd0, 2'b01);
        wait_done(edges);
        vectors++; if (edges !== WIDTH || bus.f !== 1'b1) begin errors++; $display("FAIL rmid_restart got edges=%0d f=%b exp %0d 1", edges, bus.f, WIDTH); end
        step();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A = '0; bus.B = '0; bus.z = 1'b0; bus.y = 1'b0;
        #2;
        test_reset();
        test_greater();
        test_less();
        test_equality();
        test_start_while_busy();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
